// File: rtl/fifo_uart_pkg.sv
// fifo_uart_pkg: state encoding and counter-width helper shared by the FIFO-fed UART transmitter.
package fifo_uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;
  function automatic int bit_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/uart_baud_cnt.sv
// uart_baud_cnt: clear-able bit-period counter that strobes on the last cycle of each serial bit.
module uart_baud_cnt
  import fifo_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic rclk,
  input  logic rrst_n,
  input  logic i_clr,
  output logic o_bit_end
);
  localparam int CW = bit_w(CLKS_PER_BIT);
  logic [CW-1:0] r_cnt;
  assign o_bit_end = r_cnt == CW'(CLKS_PER_BIT - 1);
  always_ff @(posedge rclk or negedge rrst_n)
    if (!rrst_n) r_cnt <= '0;
    else r_cnt <= (i_clr | o_bit_end) ? '0 : r_cnt + 1'b1;
endmodule

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops words from an async-FIFO read port and sends each as a UART frame on txd.
module fifo_uart_tx
  import fifo_uart_pkg::*;
#(
  parameter int DSIZE        = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic             rclk,
  input  logic             rrst_n,
  input  logic             rempty,
  input  logic [DSIZE-1:0] rdata,
  output logic             rinc,
  output logic             txd,
  output logic             busy,
  output logic             tx_done
);
  localparam int BW = bit_w(DSIZE + 1);
  tx_state_t r_state, w_next;
  logic [DSIZE-1:0] r_shift, w_shift;
  logic [BW-1:0] r_bit_cnt, w_bit_cnt;
  logic r_stop_cnt, w_stop_cnt;
  logic r_par, w_par, r_txd, w_txd, r_busy, r_done;
  logic w_bit_end, w_last_stop, w_load, w_clr;
  assign w_last_stop = (r_state == STOP) & w_bit_end & (r_stop_cnt == 1'(STOP_BITS - 1));
  // gated by reset so no word is popped while the transmitter is held in reset
  assign w_load = rrst_n & ~rempty & ((r_state == IDLE) | w_last_stop);
  assign w_clr  = (w_next != r_state) | (r_state == IDLE);
  assign w_par  = w_load ? (^rdata ^ 1'(PARITY_ODD)) : r_par;
  assign rinc    = w_load;
  assign txd     = r_txd;
  assign busy    = r_busy;
  assign tx_done = r_done;
  uart_baud_cnt #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .rclk(rclk), .rrst_n(rrst_n), .i_clr(w_clr), .o_bit_end(w_bit_end)
  );
  always_comb begin
    w_next     = r_state;
    w_shift    = r_shift;
    w_bit_cnt  = r_bit_cnt;
    w_stop_cnt = r_stop_cnt;
    case (r_state)
      IDLE:   if (w_load) w_next = START;
      START:  if (w_bit_end) w_next = DATA;
      DATA:   if (w_bit_end) begin
                w_shift   = r_shift >> 1;
                w_bit_cnt = r_bit_cnt + 1'b1;
                if (r_bit_cnt == BW'(DSIZE - 1)) w_next = (PARITY_EN != 0) ? PARITY : STOP;
              end
      PARITY: if (w_bit_end) w_next = STOP;
      STOP:   if (w_bit_end) begin
                w_stop_cnt = ~r_stop_cnt;
                if (w_last_stop) w_next = w_load ? START : IDLE;
              end
      default: w_next = IDLE;
    endcase
    if (w_load) begin
      w_shift    = rdata;
      w_bit_cnt  = '0;
      w_stop_cnt = 1'b0;
    end
    w_txd = (w_next == START)  ? 1'b0 :
            (w_next == DATA)   ? w_shift[0] :
            (w_next == PARITY) ? w_par : 1'b1;
  end
  always_ff @(posedge rclk or negedge rrst_n)
    if (!rrst_n) begin
      r_state    <= IDLE;
      r_shift    <= '0;
      r_bit_cnt  <= '0;
      r_stop_cnt <= 1'b0;
      r_par      <= 1'b0;
      r_txd      <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_shift    <= w_shift;
      r_bit_cnt  <= w_bit_cnt;
      r_stop_cnt <= w_stop_cnt;
      r_par      <= w_par;
      r_txd      <= w_txd;
      r_busy     <= w_next != IDLE;
      r_done     <= w_last_stop;
    end
endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: four transmitter configurations fed by FIFO models, scored frame-by-frame on txd.
module tb_fifo_uart_tx;
  logic clk = 1'b0;
  int errors = 0;
  int checks = 0;
  always #5 clk = ~clk;
  task automatic chk(input string nm, input int ln, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s lane%0d: got %0h expected %0h", nm, ln, act, exp);
    end
  endtask
  // Expected txd per clock for one frame: each serial bit repeated for 4 clocks, idle-high beyond the frame.
  function automatic logic [47:0] wave(input logic [7:0] b, input int pen, input int podd);
    logic [11:0] bits;
    logic [47:0] w;
    bits = '1;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[1+i] = b[i];
    if (pen != 0) bits[9] = (^b) ^ podd[0];
    for (int k = 0; k < 48; k++) w[k] = bits[k/4];
    return w;
  endfunction
  for (genvar g = 0; g < 4; g++) begin : lane
    localparam int PEN  = (g == 1 || g == 2) ? 1 : 0;
    localparam int PODD = (g == 2) ? 1 : 0;
    localparam int SB   = (g == 3) ? 2 : 1;
    localparam int FL   = (9 + PEN + SB) * 4;
    logic rst_n = 1'b0;
    logic rempty = 1'b1;
    logic [7:0] rdata = 8'h00;
    logic rinc, txd, busy, tx_done;
    logic [7:0] src[$];
    logic [47:0] exp_q[$];
    int rd_ptr = 0;
    int rd = 0, idx = 0, frames = 0, aborts = 0;
    bit in_f = 0, prev_rinc = 0, pend = 0, bz = 1, stray = 0, done = 0;
    logic [47:0] cap;
    fifo_uart_tx #(.DSIZE(8), .CLKS_PER_BIT(4), .PARITY_EN(PEN), .PARITY_ODD(PODD), .STOP_BITS(SB)) dut (
      .rclk(clk), .rrst_n(rst_n), .rempty(rempty), .rdata(rdata),
      .rinc(rinc), .txd(txd), .busy(busy), .tx_done(tx_done)
    );
    initial forever begin
      @(posedge clk);
      if (rinc) begin
        chk("pop_on_empty", g, rempty, 0);
        rd_ptr++;
      end
      #1;
      rempty = rd_ptr >= src.size();
      rdata = rempty ? 8'h00 : src[rd_ptr];
    end
    initial forever begin
      @(negedge clk);
      if (!rst_n) begin
        if (in_f) begin
          rd++;
          aborts++;
        end
        in_f = 0;
        idx = 0;
        prev_rinc = 0;
      end else begin
        if (in_f && idx == FL) begin
          chk("frame_txd", g, cap, rd < exp_q.size() ? exp_q[rd] : 48'h0);
          chk("frame_busy", g, bz, 1);
          chk("done_pulse", g, {stray, tx_done}, 2'b01);
          chk("next_start", g, busy, pend);
          rd++;
          frames++;
          in_f = 0;
        end
        if (!in_f && busy) begin
          chk("pop_before_start", g, prev_rinc, 1);
          in_f = 1;
          idx = 0;
          cap = '1;
          bz = 1;
          stray = 0;
        end
        if (in_f) begin
          cap[idx] = txd;
          bz &= busy;
          if (idx > 0 && tx_done) stray = 1;
          if (idx == FL - 1) pend = !rempty;
          idx++;
        end
        prev_rinc = rinc;
      end
    end
    task automatic push(input logic [7:0] b);
      @(negedge clk);
      src.push_back(b);
      exp_q.push_back(wave(b, PEN, PODD));
    endtask
    task automatic drain();
      for (int t = 0; t < 4000 && frames + aborts < src.size(); t++) @(negedge clk);
      chk("drain", g, frames + aborts, src.size());
    endtask
    initial begin
      bit ok;
      repeat (3) @(negedge clk);
      chk("reset", g, {txd, busy, tx_done, rinc}, 4'b1000);
      rst_n = 1'b1;
      push(8'hA5);
      drain();
      push(8'h00);
      push(8'hFF);
      push(8'h3C);
      drain();
      push(8'h01);
      push(8'h02);
      drain();
      push(8'h55);
      push(8'h12);
      for (int t = 0; t < 400 && !(in_f && idx >= 17); t++) @(negedge clk);
      chk("abort_reach", g, in_f && idx >= 17, 1);
      #1 rst_n = 1'b0;
      #1 chk("async_rst", g, {txd, busy, tx_done, rinc}, 4'b1000);
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b1;
      drain();
      ok = 1;
      repeat (100) begin
        @(negedge clk);
        ok &= (rinc == 1'b0) && (txd == 1'b1) && (busy == 1'b0);
      end
      chk("idle", g, ok, 1);
      repeat (15) begin
        if ($urandom_range(2) == 0) repeat ($urandom_range(50)) @(negedge clk);
        push(8'($urandom_range(255)));
      end
      drain();
      chk("pops", g, rd_ptr, src.size());
      chk("aborts", g, aborts, 1);
      done = 1;
    end
  end
  initial begin
    for (int t = 0; t < 60000 && !(lane[0].done && lane[1].done && lane[2].done && lane[3].done); t++)
      @(negedge clk);
    chk("lanes_done", 0, {lane[0].done, lane[1].done, lane[2].done, lane[3].done}, 4'hF);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
